uart_tx_framer: RTL and testbench

Serial transmitter that is the counterpart of the team's configurable UART receiver. It accepts one byte per valid/ready handshake and serialises it on TX, MSB first. Frame format comes from the same 8-bit operating-mode byte the receiver uses: baud select, 5–8 data bits, optional even/odd parity, and 1 or 2 stop bits. It sits between the packet/memory logic and the physical TX pin, with CTS/RTS flow control.

---
 rtl/uart_tx_framer.sv | 135 +++++++++++++
 tb/tb_uart_tx_framer.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_framer.sv
// UART transmitter: one byte per valid/ready handshake, framed MSB first as
// start, 5-8 data bits, optional parity, 1-2 stop bits, with CTS/RTS flow control.
module uart_tx_framer #(
  parameter logic [7:0]  MODE         = 8'h00,
  parameter int unsigned DIV_OVERRIDE = 0
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic [7:0] DATA_IN,
  input  logic       DATA_VALID,
  output logic       DATA_READY,
  input  logic       CTS,
  output logic       TX,
  output logic       RTS,
  output logic       BUSY
);

  localparam int unsigned BaudDiv = (MODE[7:6] == 2'b00) ? 10416 :
                                    (MODE[7:6] == 2'b01) ? 5208  :
                                    (MODE[7:6] == 2'b10) ? 2604  : 868;
  localparam int unsigned Div      = (DIV_OVERRIDE != 0) ? DIV_OVERRIDE : BaudDiv;
  localparam logic [15:0] DivM1    = 16'(Div - 1);
  localparam int unsigned NBits    = 5 + {30'd0, MODE[3:2]};
  localparam logic [2:0]  LastBit  = 3'(NBits - 1);
  // Selects the N bits actually sent, counted down from bit 7.
  localparam logic [7:0]  DataMask = 8'(8'hFF << (8 - NBits));
  localparam logic        ParEn    = MODE[0];
  localparam logic        ParOdd   = MODE[1];
  localparam logic        OneStop  = MODE[5];

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop1,
    StStop2
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  idx_q, idx_d;
  logic [7:0]  shift_q, shift_d;
  logic        par_q, par_d;
  logic        tx_q, tx_d;
  logic        rts_q, rts_d;
  logic        busy_q, busy_d;
  logic        bit_end;

  assign DATA_READY = (state_q == StIdle) && CTS && !Reset;
  assign TX         = tx_q;
  assign RTS        = rts_q;
  assign BUSY       = busy_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    par_d   = par_q;
    bit_end = (cnt_q == DivM1);

    if (state_q != StIdle) begin
      cnt_d = bit_end ? 16'd0 : cnt_q + 16'd1;
    end

    case (state_q)
      StIdle: begin
        if (DATA_VALID && CTS) begin
          shift_d = DATA_IN;
          par_d   = (^(DATA_IN & DataMask)) ^ ParOdd;
          cnt_d   = 16'd0;
          idx_d   = 3'd0;
          state_d = StStart;
        end
      end
      StStart: begin
        if (bit_end) state_d = StData;
      end
      StData: begin
        if (bit_end) begin
          shift_d = {shift_q[6:0], 1'b0};
          if (idx_q == LastBit) begin
            state_d = ParEn ? StParity : StStop1;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      StParity: begin
        if (bit_end) state_d = StStop1;
      end
      StStop1: begin
        if (bit_end) state_d = OneStop ? StIdle : StStop2;
      end
      StStop2: begin
        if (bit_end) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Outputs are registered, so they are derived from the next state.
    case (state_d)
      StStart:  tx_d = 1'b0;
      StData:   tx_d = shift_d[7];
      StParity: tx_d = par_d;
      default:  tx_d = 1'b1;
    endcase
    rts_d  = DATA_VALID | (state_q != StIdle);
    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= StIdle;
      cnt_q   <= 16'd0;
      idx_q   <= 3'd0;
      shift_q <= 8'd0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      rts_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
      rts_q   <= rts_d;
      busy_q  <= busy_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_framer.sv
// Bench for uart_tx_framer: four instances with different frame formats, checked
// every cycle against a frame-position model, plus literal waveform checks.
module tb_uart_tx_framer;

  localparam int NI = 4;

  logic Clock = 1'b0;
  always #5 Clock = ~Clock;

  logic [3:0]      rst, valid, cts, tx, ready, rts, busy;
  logic [3:0][7:0] din;

  logic [7:0]  mode_m [NI] = '{8'h2D, 8'h2F, 8'h00, 8'hED};
  int          ovr_m  [NI] = '{4, 4, 4, 0};
  int          divs   [NI];
  int          pos    [NI];
  int          flen   [NI];
  logic [15:0] fb     [NI];
  logic        rts_e  [NI];

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  logic hs;
  logic cap_tx [0:63];
  logic cap_b  [0:63];
  logic exp_a  [11] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 0, 1};
  logic exp_b  [11] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1, 1};
  logic exp_c  [8]  = '{0, 1, 1, 1, 1, 1, 1, 1};

  uart_tx_framer #(.MODE(8'h2D), .DIV_OVERRIDE(4)) u0 (
    .Clock(Clock), .Reset(rst[0]), .DATA_IN(din[0]), .DATA_VALID(valid[0]),
    .DATA_READY(ready[0]), .CTS(cts[0]), .TX(tx[0]), .RTS(rts[0]), .BUSY(busy[0])
  );
  uart_tx_framer #(.MODE(8'h2F), .DIV_OVERRIDE(4)) u1 (
    .Clock(Clock), .Reset(rst[1]), .DATA_IN(din[1]), .DATA_VALID(valid[1]),
    .DATA_READY(ready[1]), .CTS(cts[1]), .TX(tx[1]), .RTS(rts[1]), .BUSY(busy[1])
  );
  uart_tx_framer #(.MODE(8'h00), .DIV_OVERRIDE(4)) u2 (
    .Clock(Clock), .Reset(rst[2]), .DATA_IN(din[2]), .DATA_VALID(valid[2]),
    .DATA_READY(ready[2]), .CTS(cts[2]), .TX(tx[2]), .RTS(rts[2]), .BUSY(busy[2])
  );
  uart_tx_framer #(.MODE(8'hED), .DIV_OVERRIDE(0)) u3 (
    .Clock(Clock), .Reset(rst[3]), .DATA_IN(din[3]), .DATA_VALID(valid[3]),
    .DATA_READY(ready[3]), .CTS(cts[3]), .TX(tx[3]), .RTS(rts[3]), .BUSY(busy[3])
  );

  task automatic chk(string name, int inst, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s inst%0d cycle %0d: got %0d expected %0d", name, inst, cyc, act, exp);
    end
  endtask

  // Frame as a list of line levels: start, N data bits MSB first, parity, stops.
  task automatic build_frame(int i, logic [7:0] b);
    int   n, k;
    logic p;
    n = 5 + int'(mode_m[i][3:2]);
    k = 0;
    p = 1'b0;
    fb[i] = '1;
    fb[i][k] = 1'b0; k++;
    for (int j = 0; j < n; j++) begin
      fb[i][k] = b[7-j]; p ^= b[7-j]; k++;
    end
    if (mode_m[i][0]) begin fb[i][k] = p ^ mode_m[i][1]; k++; end
    k++;
    if (!mode_m[i][5]) k++;
    flen[i] = k;
  endtask

  task automatic model_tick();
    for (int i = 0; i < NI; i++) begin
      if (rst[i]) begin
        pos[i] = -1; rts_e[i] = 1'b0;
      end else begin
        rts_e[i] = valid[i] | (pos[i] >= 0);
        if (pos[i] < 0) begin
          if (valid[i] && cts[i]) begin build_frame(i, din[i]); pos[i] = 0; end
        end else begin
          pos[i]++;
          if (pos[i] == flen[i] * divs[i]) pos[i] = -1;
        end
      end
    end
  endtask

  task automatic compare_all();
    logic et;
    for (int i = 0; i < NI; i++) begin
      et = (pos[i] < 0) ? 1'b1 : fb[i][pos[i] / divs[i]];
      chk("tx", i, 32'(tx[i]), 32'(et));
      chk("busy", i, 32'(busy[i]), 32'(pos[i] >= 0));
      chk("rts", i, 32'(rts[i]), 32'(rts_e[i]));
      chk("ready", i, 32'(ready[i]), 32'((pos[i] < 0) && cts[i] && !rst[i]));
    end
  endtask

  task automatic cycle();
    @(posedge Clock);
    model_tick();
    @(negedge Clock);
    cyc++;
    compare_all();
  endtask

  task automatic send(int i, logic [7:0] b);
    int w;
    valid[i] = 1'b1; din[i] = b; #1;
    w = 0;
    while (!ready[i] && w < 200) begin cycle(); #1; w++; end
    chk("handshake", i, 32'(ready[i]), 32'd1);
    cycle();
    valid[i] = 1'b0;
  endtask

  task automatic capture(int i, int n);
    for (int c = 0; c < n; c++) begin
      cap_tx[c] = tx[i]; cap_b[c] = busy[i];
      cycle();
    end
  endtask

  function automatic int busy_count(int n);
    int s = 0;
    for (int c = 0; c < n; c++) s += int'(cap_b[c]);
    return s;
  endfunction

  initial begin
    int w, start_len, gap;
    for (int i = 0; i < NI; i++) begin
      pos[i] = -1; rts_e[i] = 1'b0; fb[i] = '1; flen[i] = 0;
      if (ovr_m[i] != 0) divs[i] = ovr_m[i];
      else case (mode_m[i][7:6])
        2'b00:   divs[i] = 10416;
        2'b01:   divs[i] = 5208;
        2'b10:   divs[i] = 2604;
        default: divs[i] = 868;
      endcase
    end
    rst = '1; valid = '0; cts = '1; din = '0;
    repeat (3) cycle();
    for (int i = 0; i < NI; i++) begin
      chk("reset_tx", i, 32'(tx[i]), 32'd1);
      chk("reset_ready", i, 32'(ready[i]), 32'd0);
      chk("reset_rts", i, 32'(rts[i]), 32'd0);
      chk("reset_busy", i, 32'(busy[i]), 32'd0);
    end
    rst = '0;
    cycle();

    // 8 bits, even parity, one stop
    send(0, 8'hA5);
    capture(0, 50);
    chk("a_busy_len", 0, 32'(busy_count(50)), 32'd44);
    for (int k = 0; k < 11; k++) chk("a_bit", k, 32'(cap_tx[4*k+2]), 32'(exp_a[k]));
    chk("a_idle_after", 0, 32'(cap_tx[44]), 32'd1);

    // CTS held low blocks the handshake; a mid-frame drop does not abort
    cts[1] = 1'b0; valid[1] = 1'b1; din[1] = 8'hA5; #1;
    chk("cts_ready_low", 1, 32'(ready[1]), 32'd0);
    cycle();
    chk("cts_rts_high", 1, 32'(rts[1]), 32'd1);
    chk("cts_tx_idle", 1, 32'(tx[1]), 32'd1);
    cycle();
    cts[1] = 1'b1;
    send(1, 8'hA5);
    cts[1] = 1'b0;
    capture(1, 50);
    cts[1] = 1'b1;
    chk("b_busy_len", 1, 32'(busy_count(50)), 32'd44);
    for (int k = 0; k < 11; k++) chk("b_bit", k, 32'(cap_tx[4*k+2]), 32'(exp_b[k]));

    // 5 bits, no parity, two stops: low three data bits never appear
    send(2, 8'hF8);
    capture(2, 40);
    chk("c_busy_len", 2, 32'(busy_count(40)), 32'd32);
    for (int k = 0; k < 8; k++) chk("c_bit", k, 32'(cap_tx[4*k+2]), 32'(exp_c[k]));

    // Reset during the third data bit abandons the frame
    send(0, 8'hA5);
    repeat (13) cycle();
    rst[0] = 1'b1;
    cycle();
    chk("rst_tx", 0, 32'(tx[0]), 32'd1);
    chk("rst_busy", 0, 32'(busy[0]), 32'd0);
    chk("rst_rts", 0, 32'(rts[0]), 32'd0);
    rst[0] = 1'b0;
    cycle();
    send(0, 8'hA5);
    capture(0, 50);
    chk("d_busy_len", 0, 32'(busy_count(50)), 32'd44);
    for (int k = 0; k < 11; k++) chk("d_bit", k, 32'(cap_tx[4*k+2]), 32'(exp_a[k]));

    // Random traffic, CTS toggling, occasional resets
    for (int i = 0; i < 3; i++) begin
      for (int c = 0; c < 1500; c++) begin
        if ($urandom_range(0, 7) == 0) cts[i] = ~cts[i];
        if (!valid[i]) begin
          din[i] = 8'($urandom);
          if ($urandom_range(0, 3) == 0) valid[i] = 1'b1;
        end
        rst[i] = ($urandom_range(0, 399) == 0);
        #1;
        hs = valid[i] && ready[i];
        cycle();
        if (hs) begin valid[i] = 1'($urandom_range(0, 1)); din[i] = 8'($urandom); end
      end
      valid[i] = 1'b0; cts[i] = 1'b1; rst[i] = 1'b0;
      repeat (50) cycle();
    end

    // Real baud divider and back-to-back frames
    valid[3] = 1'b1; din[3] = 8'hC3; #1;
    w = 0;
    while (!ready[3] && w < 200) begin cycle(); #1; w++; end
    cycle();
    din[3] = 8'h81;
    start_len = 0; w = 0;
    while (tx[3] == 1'b0 && w < 2000) begin start_len++; cycle(); w++; end
    chk("e_start_len", 3, 32'(start_len), 32'd868);
    w = 0;
    while (busy[3] && w < 20000) begin cycle(); w++; end
    gap = 0;
    while (!busy[3] && w < 20000) begin
      #1; hs = ready[3] && valid[3];
      cycle();
      if (hs) valid[3] = 1'b0;
      gap++; w++;
    end
    chk("e_gap", 3, 32'(gap), 32'd1);
    w = 0;
    while (busy[3] && w < 20000) begin cycle(); w++; end
    chk("e_done", 3, 32'(busy[3]), 32'd0);
    repeat (5) cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
